// File: rtl/alu_issue.sv
// Issue stage between register read and execute: decodes an RV32 subset into the
// 3-bit ALU control code and registers the ALU operands behind a valid/ready handshake.
module alu_issue #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        illegal_o,
  output logic        valid_o,
  input  logic        ready_i
);

  typedef enum logic [1:0] {EMPTY, FULL, MUL_WAIT} state_t;

  // Wait-counter start value; unused when MUL_CYCLES is 1.
  localparam logic [2:0] CNT_INIT = (MUL_CYCLES > 1) ? 3'(MUL_CYCLES - 2) : 3'd0;

  state_t      state_reg;
  logic [2:0]  cnt_reg;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;

  logic [2:0]  ctrl_next;
  logic [31:0] data2_next;
  logic        reg_write_next;
  logic        illegal_next;
  logic        is_mul;
  logic        accept;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};

  always_comb begin
    ctrl_next      = 3'b000;
    data2_next     = rs2_data_i;
    reg_write_next = 1'b0;
    illegal_next   = 1'b0;
    is_mul         = 1'b0;
    case (opcode)
      7'b0110011: begin
        reg_write_next = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: ctrl_next = 3'b000;
          {7'b0100000, 3'b000}: ctrl_next = 3'b001;
          {7'b0000000, 3'b111}: ctrl_next = 3'b010;
          {7'b0000000, 3'b110}: ctrl_next = 3'b011;
          {7'b0000001, 3'b000}: begin
            ctrl_next = 3'b100;
            is_mul    = 1'b1;
          end
          default: begin
            reg_write_next = 1'b0;
            illegal_next   = 1'b1;
          end
        endcase
      end
      7'b0010011, 7'b0000011: begin
        // addi (funct3 000) and lw (funct3 010) share the I-immediate add path
        if ((opcode == 7'b0010011 && funct3 == 3'b000) ||
            (opcode == 7'b0000011 && funct3 == 3'b010)) begin
          data2_next     = imm_i;
          reg_write_next = 1'b1;
        end else begin
          illegal_next = 1'b1;
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) data2_next = imm_s;
        else                  illegal_next = 1'b1;
      end
      7'b1100011: begin
        if (funct3 == 3'b000) ctrl_next = 3'b001;
        else                  illegal_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
  end

  assign ready_o = !rst_i && !flush_i &&
                   ((state_reg == EMPTY) || ((state_reg == FULL) && ready_i));
  assign accept  = valid_i && ready_o && !flush_i;
  assign valid_o = (state_reg == FULL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= EMPTY;
      cnt_reg     <= 3'd0;
      alu_data1_o <= 32'd0;
      alu_data2_o <= 32'd0;
      alu_ctrl_o  <= 3'd0;
      rd_o        <= 5'd0;
      reg_write_o <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      state_reg <= EMPTY;
    end else if (accept) begin
      alu_data1_o <= rs1_data_i;
      alu_data2_o <= data2_next;
      alu_ctrl_o  <= ctrl_next;
      rd_o        <= instr_i[11:7];
      reg_write_o <= reg_write_next;
      illegal_o   <= illegal_next;
      if (is_mul && MUL_CYCLES > 1) begin
        state_reg <= MUL_WAIT;
        cnt_reg   <= CNT_INIT;
      end else begin
        state_reg <= FULL;
      end
    end else begin
      case (state_reg)
        FULL:     if (ready_i) state_reg <= EMPTY;
        MUL_WAIT: begin
          if (cnt_reg == 3'd0) state_reg <= FULL;
          else                 cnt_reg   <= cnt_reg - 3'd1;
        end
        default:  state_reg <= state_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with MUL_CYCLES = 3 and hand-computed expectations.
module tb_alu_issue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic        illegal_o;
  logic        valid_o;
  logic        ready_i;

  int tests = 0;
  int fails = 0;

  alu_issue #(.MUL_CYCLES(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_ctrl_o(alu_ctrl_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
    .illegal_o(illegal_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] stream_instr [4];
  logic [2:0]  stream_ctrl  [4];

  initial begin
    stream_instr = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h80008193};
    stream_ctrl  = '{3'b001, 3'b010, 3'b011, 3'b000};

    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    instr_i = 32'h0; rs1_data_i = 32'h0; rs2_data_i = 32'h0;
    #1;
    chk("ready_in_reset", 32'(ready_o), 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_data1", alu_data1_o, 32'd0);
    chk("rst_ctrl",  32'(alu_ctrl_o), 32'd0);

    // add x3,x1,x2
    valid_i = 1'b1; instr_i = 32'h002081B3; rs1_data_i = 32'd5; rs2_data_i = 32'd7;
    step();
    $display("[TB] add issued");
    valid_i = 1'b0;
    chk("add_valid", 32'(valid_o), 32'd1);
    chk("add_ctrl",  32'(alu_ctrl_o), 32'd0);
    chk("add_data1", alu_data1_o, 32'd5);
    chk("add_data2", alu_data2_o, 32'd7);
    chk("add_rd",    32'(rd_o), 32'd3);
    chk("add_rw",    32'(reg_write_o), 32'd1);
    chk("add_ill",   32'(illegal_o), 32'd0);

    // sw x2,-4(x1): back to back from FULL
    valid_i = 1'b1; instr_i = 32'hFE20AE23; rs1_data_i = 32'h100; rs2_data_i = 32'h55;
    #1;
    chk("full_ready", 32'(ready_o), 32'd1);
    step();
    $display("[TB] sw issued");
    chk("sw_valid", 32'(valid_o), 32'd1);
    chk("sw_data1", alu_data1_o, 32'h100);
    chk("sw_data2", alu_data2_o, 32'hFFFFFFFC);
    chk("sw_ctrl",  32'(alu_ctrl_o), 32'd0);
    chk("sw_rw",    32'(reg_write_o), 32'd0);

    // sub/and/or/addi streamed at one per cycle
    rs1_data_i = 32'd20; rs2_data_i = 32'd3;
    for (int i = 0; i < 4; i++) begin
      instr_i = stream_instr[i];
      step();
      $display("[TB] stream op %0d issued ctrl=%b", i, alu_ctrl_o);
      chk("stream_valid", 32'(valid_o), 32'd1);
      chk("stream_ctrl",  32'(alu_ctrl_o), 32'(stream_ctrl[i]));
    end
    chk("addi_data2", alu_data2_o, 32'hFFFFF800);
    valid_i = 1'b0;
    step();
    chk("drain_valid", 32'(valid_o), 32'd0);

    // lw x3,8(x1) then beq x1,x2
    valid_i = 1'b1; instr_i = 32'h0080A183; rs1_data_i = 32'h40; rs2_data_i = 32'h9;
    step();
    $display("[TB] lw issued");
    chk("lw_data2", alu_data2_o, 32'd8);
    chk("lw_rw",    32'(reg_write_o), 32'd1);
    instr_i = 32'h00208063;
    step();
    $display("[TB] beq issued");
    valid_i = 1'b0;
    chk("beq_ctrl",  32'(alu_ctrl_o), 32'd1);
    chk("beq_data2", alu_data2_o, 32'h9);
    chk("beq_rw",    32'(reg_write_o), 32'd0);
    step();

    // mul with MUL_CYCLES = 3: accepted at edge N, valid after N+2
    valid_i = 1'b1; instr_i = 32'h022081B3; rs1_data_i = 32'd6; rs2_data_i = 32'd7;
    step();
    $display("[TB] mul accepted");
    valid_i = 1'b0; rs1_data_i = 32'hDEAD; rs2_data_i = 32'hBEEF;
    for (int i = 0; i < 2; i++) begin
      chk("mul_wait_valid", 32'(valid_o), 32'd0);
      chk("mul_wait_ready", 32'(ready_o), 32'd0);
      chk("mul_ctrl",  32'(alu_ctrl_o), 32'd4);
      chk("mul_data1", alu_data1_o, 32'd6);
      chk("mul_data2", alu_data2_o, 32'd7);
      step();
    end
    chk("mul_valid", 32'(valid_o), 32'd1);
    chk("mul_data1_final", alu_data1_o, 32'd6);

    // Stall in FULL with a pending instruction upstream
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h002081B3; rs1_data_i = 32'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_ready", 32'(ready_o), 32'd0);
      step();
      $display("[TB] stall cycle %0d", i);
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_ctrl",  32'(alu_ctrl_o), 32'd4);
      chk("stall_data1", alu_data1_o, 32'd6);
    end
    flush_i = 1'b1;
    #1;
    chk("flush_ready", 32'(ready_o), 32'd0);
    step();
    $display("[TB] flush");
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_ctrl",  32'(alu_ctrl_o), 32'd4);
    chk("flush_data1", alu_data1_o, 32'd6);

    // Illegal opcode
    valid_i = 1'b1; instr_i = 32'h0000007F; rs1_data_i = 32'h11; rs2_data_i = 32'h22;
    step();
    $display("[TB] illegal issued");
    valid_i = 1'b0;
    chk("ill_valid", 32'(valid_o), 32'd1);
    chk("ill_flag",  32'(illegal_o), 32'd1);
    chk("ill_ctrl",  32'(alu_ctrl_o), 32'd0);
    chk("ill_rw",    32'(reg_write_o), 32'd0);
    chk("ill_data1", alu_data1_o, 32'h11);
    step();

    // Reset during MUL_WAIT
    valid_i = 1'b1; instr_i = 32'h022081B3; rs1_data_i = 32'd9; rs2_data_i = 32'd3;
    step();
    $display("[TB] mul accepted before reset");
    valid_i = 1'b0;
    chk("mw_valid", 32'(valid_o), 32'd0);
    chk("mw_ill",   32'(illegal_o), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("mw_rst_ready", 32'(ready_o), 32'd0);
    step();
    $display("[TB] reset during mul wait");
    rst_i = 1'b0;
    #1;
    chk("post_rst_valid", 32'(valid_o), 32'd0);
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    chk("post_rst_data1", alu_data1_o, 32'd0);
    chk("post_rst_data2", alu_data2_o, 32'd0);
    chk("post_rst_ctrl",  32'(alu_ctrl_o), 32'd0);
    chk("post_rst_rd",    32'(rd_o), 32'd0);
    chk("post_rst_rw",    32'(reg_write_o), 32'd0);
    chk("post_rst_ill",   32'(illegal_o), 32'd0);
    step();
    step();
    chk("post_rst_stays_empty", 32'(valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage that sits in front of the 3-bit-control ALU.
- Decodes a RV32 subset (add, sub, and, or, mul, addi, lw, sw, beq) into the ALU control code.
- Selects and registers both ALU operands.
- Carries the decoded op through a valid/ready pipeline register.
- Holds multiplies for a programmable number of cycles so the combinational multiply path is given a multicycle allowance.

It sits between register-file read (ID) and execute (EX) and drives the ALU's data1/data2/ctrl inputs directly.

## Interface
- MUL_CYCLES, default 2: cycles the ALU operands of a mul are held stable before valid_o asserts; legal range 1..8.
- clk_i  in  1  clock; everything updates on the rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- valid_i  in  1  upstream has an instruction.
- ready_o  out  1  stage can accept this cycle.
- instr_i  in  32  instruction word.
- rs1_data_i  in  32  register rs1 value.
- rs2_data_i  in  32  register rs2 value.
- flush_i  in  1  discard held and incoming instruction.
- alu_data1_o  out  32  ALU operand 1 (registered).
- alu_data2_o  out  32  ALU operand 2 (registered).
- alu_ctrl_o  out  3  ALU control: 000 add, 001 sub, 010 and, 011 or, 100 mul.
- rd_o  out  5  destination register, instr[11:7].
- reg_write_o  out  1  instruction writes rd.
- illegal_o  out  1  held instruction is not in the supported subset.
- valid_o  out  1  outputs are a valid, settled issue.
- ready_i  in  1  EX consumes the issue this cycle.

## Operation
**Decode.**
- opcode = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25].
- Opcode 0110011 (R-type), data2 = rs2:
  - funct7/funct3 0000000/000 → add (000)
  - 0100000/000 → sub (001)
  - 0000000/111 → and (010)
  - 0000000/110 → or (011)
  - 0000001/000 → mul (100)
  - reg_write = 1.
- Opcode 0010011, funct3 000 (addi): add, data2 = sext(instr[31:20]), reg_write = 1.
- Opcode 0000011, funct3 010 (lw): add, data2 = sext(instr[31:20]), reg_write = 1.
- Opcode 0100011, funct3 010 (sw): add, data2 = sext({instr[31:25], instr[11:7]}), reg_write = 0.
- Opcode 1100011, funct3 000 (beq): sub, data2 = rs2, reg_write = 0.
- Anything else: illegal = 1, ctrl 000, reg_write = 0, operands still registered; the issue still flows through the handshake.
- data1 is always rs1_data_i.

**State machine.**
- EMPTY: valid_o = 0, ready_o = 1.
- FULL: valid_o = 1, ready_o = ready_i.
- MUL_WAIT: valid_o = 0, ready_o = 0, down-counter cnt of 3 bits.

**Accept and transitions.**
- Accept = valid_i & ready_o & !flush_i. On accept, all output registers load.
- EMPTY or FULL, accept of a non-mul, or of a mul with MUL_CYCLES = 1 → FULL.
- EMPTY or FULL, accept of a mul with MUL_CYCLES > 1 → MUL_WAIT, cnt = MUL_CYCLES − 2.
- FULL, ready_i with no accept → EMPTY.
- MUL_WAIT: cnt == 0 → FULL; otherwise cnt decrements.

**Flush.**
- flush_i overrides everything except reset: next state EMPTY, nothing accepted.
- ready_o is forced to 0 while flush_i = 1.

**Reset.**
- State EMPTY, cnt 0.
- All outputs 0: alu_data1_o, alu_data2_o, alu_ctrl_o, rd_o, reg_write_o, illegal_o, valid_o.
- ready_o = 1 after reset, 0 while rst_i is high.
- Reset mid-MUL_WAIT or mid-FULL drops the instruction.

## Timing
- Non-mul: accepted at edge N → valid_o high after edge N; 1-cycle latency.
- Mul: accepted at edge N → operands/ctrl stable from edge N; valid_o high after edge N + MUL_CYCLES − 1.
- ready_o is combinational from state, ready_i and flush_i.
- Back-to-back issue: in FULL with ready_i = 1 and valid_i = 1, the stage consumes and reloads on the same edge, giving 1 issue per cycle.
- Stall: in FULL with ready_i = 0, all outputs are held unchanged and ready_o = 0.
- Output registers change only on accept or reset. A flush clears valid_o only; data outputs keep their stale values.

## Test plan
- Reset, then issue add x3,x1,x2 (0x002081B3) with rs1 = 5, rs2 = 7, ready_i = 1:
  - next cycle valid_o = 1, ctrl 000, data1 5, data2 7, rd 3, reg_write 1.
- sw x2,-4(x1) (0xFE20AE23), rs1 = 0x100:
  - data2 = 0xFFFFFFFC, ctrl 000, reg_write 0.
- Stream sub/and/or/addi back to back:
  - ctrl sequence 001, 010, 011, 000.
  - addi imm 0x800 gives data2 0xFFFFF800.
  - valid_o stays high continuously.
- MUL_CYCLES = 3, mul (0x022081B3) with rs1 = 6, rs2 = 7, accepted at edge N:
  - valid_o rises after edge N+2.
  - ready_o = 0 for 2 cycles.
  - ctrl 100 and operands 6/7 constant from edge N onward.
- Hold ready_i = 0 for 4 cycles in FULL:
  - outputs frozen, ready_o = 0.
  - Then assert flush_i with valid_i = 1: valid_o = 0 next cycle and the new instruction is not accepted.
- Illegal opcode 0x0000007F, then rst_i during MUL_WAIT:
  - illegal_o = 1, ctrl 000, reg_write 0.
  - After the reset edge, all outputs are 0, state EMPTY, and ready_o returns to 1.
